// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters onto the single-ported data memory.
// One command pulse per grant, waits out the memory stall with a watchdog, then pulses done.
module data_mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sign_mask,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sign_mask,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  // Abort is taken on the TIMEOUT-th stalled WAIT cycle
  localparam logic [3:0] WD_LAST = 4'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        last_grant_reg, grant_reg;
  logic [3:0]  wd_cnt_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  mask_reg;
  logic        write_reg;

  logic [1:0]  req;
  logic [31:0] addr_in  [2];
  logic [31:0] wdata_in [2];
  logic [3:0]  mask_in  [2];
  logic [1:0]  write_in;
  logic [63:0] rdata_vec;
  logic [1:0]  err_vec;
  logic        pick, start, wd_expired, wait_exit;

  assign req         = {m1_req, m0_req};
  assign write_in    = {m1_write, m0_write};
  assign addr_in[0]  = m0_addr;
  assign addr_in[1]  = m1_addr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;
  assign mask_in[0]  = m0_sign_mask;
  assign mask_in[1]  = m1_sign_mask;

  // On a tie the requester that did not win last time goes next
  always_comb begin
    pick = (req[0] & req[1]) ? ~last_grant_reg : req[1];
  end

  assign start      = (state_reg == ST_IDLE) && (|req) && !mem_stall;
  assign wd_expired = (wd_cnt_reg == WD_LAST);
  assign wait_exit  = (state_reg == ST_WAIT) && (!mem_stall || wd_expired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (wait_exit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    m0_done      = 1'b0;
    m1_done      = 1'b0;
    case (state_reg)
      ST_ISSUE: begin
        mem_memread  = ~write_reg;
        mem_memwrite = write_reg;
      end
      ST_RESP: begin
        m0_done = ~grant_reg;
        m1_done = grant_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      wd_cnt_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
      write_reg      <= 1'b0;
    end else begin
      if (start) begin
        addr_reg       <= addr_in[pick];
        wdata_reg      <= wdata_in[pick];
        mask_reg       <= mask_in[pick];
        write_reg      <= write_in[pick];
        last_grant_reg <= pick;
        grant_reg      <= pick;
      end
      if (state_reg == ST_WAIT && !wait_exit) wd_cnt_reg <= wd_cnt_reg + 4'd1;
      else if (state_reg == ST_RESP)           wd_cnt_reg <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0] rdata_r;
      logic        err_r;
      // Leaving WAIT with stall still high means the watchdog fired
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_r <= '0;
          err_r   <= 1'b0;
        end else if (start && pick == 1'(gi)) begin
          err_r <= 1'b0;
        end else if (wait_exit && grant_reg == 1'(gi)) begin
          rdata_r <= (mem_stall || write_reg) ? 32'd0 : mem_read_data;
          err_r   <= mem_stall;
        end
      end
      assign rdata_vec[gi*32 +: 32] = rdata_r;
      assign err_vec[gi]            = err_r;
    end
  endgenerate

  assign m0_rdata       = rdata_vec[31:0];
  assign m1_rdata       = rdata_vec[63:32];
  assign m0_err         = err_vec[0];
  assign m1_err         = err_vec[1];
  assign mem_addr       = addr_reg;
  assign mem_write_data = wdata_reg;
  assign mem_sign_mask  = mask_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small stalling memory model.
// Each scenario task drives its own stimulus and checks hand-computed values.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_sign_mask = '0;
  logic        m0_done, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_sign_mask = '0;
  logic        m1_done, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_read_data = '0;
  logic        mem_stall;

  logic        hold_stall = 1'b0;
  logic        model_stall = 1'b0;
  int          model_cnt = 0;
  int          cmd_cnt = 0, consec_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  logic        prev_cmd = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_mask = '0;
  logic        cmd_write = 1'b0;
  int          grants[$];
  int          checks = 0, fails = 0;

  assign mem_stall = hold_stall | model_stall;

  always #5 clk = ~clk;

  data_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sign_mask(m0_sign_mask), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sign_mask(m1_sign_mask), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall)
  );

  // Memory model: stall covers 2 WAIT samples for loads, 3 for stores; plus bus monitor
  always @(negedge clk) begin
    if (mem_memread | mem_memwrite) begin
      cmd_cnt     <= cmd_cnt + 1;
      cmd_addr    <= mem_addr;
      cmd_data    <= mem_write_data;
      cmd_mask    <= mem_sign_mask;
      cmd_write   <= mem_memwrite;
      model_stall <= 1'b1;
      model_cnt   <= mem_memwrite ? 4 : 3;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_stall <= 1'b0;
    end
    if (prev_cmd && (mem_memread | mem_memwrite)) consec_cnt <= consec_cnt + 1;
    prev_cmd <= mem_memread | mem_memwrite;
    if (m0_done) begin
      done0_cnt <= done0_cnt + 1;
      grants.push_back(0);
      $display("txn m0 done rdata=%h err=%b t=%0t", m0_rdata, m0_err, $time);
    end
    if (m1_done) begin
      done1_cnt <= done1_cnt + 1;
      grants.push_back(1);
      $display("txn m1 done rdata=%h err=%b t=%0t", m1_rdata, m1_err, $time);
    end
  end

  // Call just after a negedge with req set: next posedge is the sampling edge.
  task automatic wait_done(input int port, output int lat);
    lat = 0;
    @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((port == 0 && m0_done) || (port == 1 && m1_done)) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic wait_cmd();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_memread | mem_memwrite) break;
    end
  endtask

  task automatic test_reset();
    logic [137:0] outs;
    int c0, lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
            m0_done, m0_rdata, m0_err, m1_done, m1_rdata, m1_err};
    checks++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_read_data = 32'h1111_2222;
    m0_addr = 32'h0000_0100; m0_write = 1'b0; m0_req = 1'b1;
    wait_cmd();
    checks++;
    if (mem_addr !== 32'h0000_0100) begin fails++; $display("FAIL reset_pre_addr: got %h want 00000100", mem_addr); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    hold_stall = 1'b1;
    #1;
    outs = {mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
            m0_done, m0_rdata, m0_err, m1_done, m1_rdata, m1_err};
    checks++;
    if (outs !== '0) begin fails++; $display("FAIL async_reset: got %h want 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    c0 = cmd_cnt;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (cmd_cnt !== c0) begin fails++; $display("FAIL reset_stall_gate: got %0d cmds want %0d", cmd_cnt, c0); end
    hold_stall = 1'b0;
    wait_done(0, lat);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL reset_recover_lat: got %0d want 4", lat); end
    checks++;
    if (m0_rdata !== 32'h1111_2222) begin fails++; $display("FAIL reset_recover_rdata: got %h want 11112222", m0_rdata); end
    m0_req = 1'b0;
  endtask

  task automatic test_single_load();
    int c0, d0, lat;
    @(negedge clk); #1;
    c0 = cmd_cnt; d0 = done0_cnt;
    mem_read_data = 32'hDEAD_BEEF;
    m0_addr = 32'h0000_4004; m0_write = 1'b0; m0_sign_mask = 4'b0010; m0_req = 1'b1;
    wait_done(0, lat);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL load_latency: got %0d want 4", lat); end
    checks++;
    if (m0_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h want deadbeef", m0_rdata); end
    checks++;
    if (m0_err !== 1'b0) begin fails++; $display("FAIL load_err: got %b want 0", m0_err); end
    m0_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (cmd_cnt - c0 !== 1 || cmd_write !== 1'b0 || cmd_addr !== 32'h0000_4004) begin
      fails++; $display("FAIL load_cmd: got n=%0d w=%b a=%h want n=1 w=0 a=00004004", cmd_cnt - c0, cmd_write, cmd_addr);
    end
    checks++;
    if (m0_done !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF || done0_cnt - d0 !== 1) begin
      fails++; $display("FAIL load_hold: got done=%b rdata=%h n=%0d want 0 deadbeef 1", m0_done, m0_rdata, done0_cnt - d0);
    end
  endtask

  task automatic test_single_store();
    int c0, d0, lat;
    @(negedge clk); #1;
    c0 = cmd_cnt; d0 = done0_cnt;
    mem_read_data = 32'hFFFF_FFFF;
    m1_addr = 32'h0000_4008; m1_wdata = 32'h1234_5678; m1_sign_mask = 4'b0100;
    m1_write = 1'b1; m1_req = 1'b1;
    wait_done(1, lat);
    checks++;
    if (lat !== 5) begin fails++; $display("FAIL store_latency: got %0d want 5", lat); end
    checks++;
    if (m1_rdata !== 32'd0 || m1_err !== 1'b0) begin
      fails++; $display("FAIL store_resp: got rdata=%h err=%b want 0 0", m1_rdata, m1_err);
    end
    m1_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (cmd_cnt - c0 !== 1 || cmd_write !== 1'b1 || cmd_addr !== 32'h0000_4008 ||
        cmd_data !== 32'h1234_5678 || cmd_mask !== 4'b0100) begin
      fails++; $display("FAIL store_cmd: got n=%0d w=%b a=%h d=%h m=%b want 1 1 00004008 12345678 0100",
                        cmd_cnt - c0, cmd_write, cmd_addr, cmd_data, cmd_mask);
    end
    checks++;
    if (done0_cnt !== d0) begin fails++; $display("FAIL store_no_m0_done: got %0d want %0d", done0_cnt, d0); end
  endtask

  task automatic test_back_to_back();
    int c0, k0, n;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    @(negedge clk); #1;
    c0 = cmd_cnt; k0 = consec_cnt;
    grants.delete();
    mem_read_data = 32'hA5A5_A5A5;
    m0_addr = 32'h0000_0010; m0_write = 1'b0; m0_req = 1'b1;
    m1_addr = 32'h0000_0020; m1_wdata = 32'h5A5A_5A5A; m1_write = 1'b1; m1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (m0_done | m1_done) n++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++;
    if (grants.size() !== 4) begin fails++; $display("FAIL contention_count: got %0d want 4", grants.size()); end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] !== exp_g[i]) begin fails++; $display("FAIL contention_grant%0d: got m%0d want m%0d", i, grants[i], exp_g[i]); end
    end
    checks++;
    if (consec_cnt !== k0) begin fails++; $display("FAIL contention_consec: got %0d want %0d", consec_cnt - k0, 0); end
    checks++;
    if (cmd_cnt - c0 !== 4) begin fails++; $display("FAIL contention_cmds: got %0d want 4", cmd_cnt - c0); end
  endtask

  task automatic test_watchdog();
    int c0, lat;
    @(negedge clk); #1;
    mem_read_data = 32'hCAFE_F00D;
    m0_addr = 32'h0000_0300; m0_write = 1'b0; m0_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_memread !== 1'b1) begin fails++; $display("FAIL wd_issue: got %b want 1", mem_memread); end
    hold_stall = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (m0_done) break;
    end
    checks++;
    if (lat !== 16) begin fails++; $display("FAIL wd_latency: got %0d want 16", lat); end
    checks++;
    if (m0_err !== 1'b1 || m0_rdata !== 32'd0) begin
      fails++; $display("FAIL wd_resp: got err=%b rdata=%h want 1 0", m0_err, m0_rdata);
    end
    m0_req = 1'b0;
    m1_addr = 32'h0000_2000; m1_wdata = 32'h0000_0001; m1_sign_mask = 4'b1111;
    m1_write = 1'b1; m1_req = 1'b1;
    #1;
    c0 = cmd_cnt;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cmd_cnt !== c0) begin fails++; $display("FAIL wd_idle_gate: got %0d cmds want %0d", cmd_cnt, c0); end
    hold_stall = 1'b0;
    wait_done(1, lat);
    checks++;
    if (lat !== 5 || m1_err !== 1'b0) begin fails++; $display("FAIL led_store: got lat=%0d err=%b want 5 0", lat, m1_err); end
    checks++;
    if (m0_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", m0_err); end
    m1_req = 1'b0;
  endtask

  task automatic test_req_drop();
    int c0, d0, lat;
    @(negedge clk); #1;
    c0 = cmd_cnt; d0 = done0_cnt;
    mem_read_data = 32'h0BAD_F00D;
    m0_addr = 32'h0000_0500; m0_write = 1'b0; m0_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b0) begin fails++; $display("FAIL err_clear_on_grant: got %b want 0", m0_err); end
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m0_done) break;
      @(posedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || m0_rdata !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL drop_done: got lat=%0d rdata=%h want 4 0badf00d", lat, m0_rdata);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (cmd_cnt - c0 !== 1 || done0_cnt - d0 !== 1) begin
      fails++; $display("FAIL drop_single: got cmds=%0d dones=%0d want 1 1", cmd_cnt - c0, done0_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_back_to_back();
    test_watchdog();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
